digi_ota_array: RTL
===================

# digi_ota_array

Parametrised multi-channel successor to the single-channel digital OTA macro: N independent differential digital comparators on single-ended pin pairs (vip, vin), with a tri-state output per channel. Unlike the combinational original, every channel is clocked: 2-FF input synchronisers, a debounce counter, a per-channel drive state machine, and a selectable integrator mode. Sits between the analog pin pairs and the output pad drivers of the tile.

## Interface
Parameters:
- N_CH, 4, number of channels
- DEB, 2, consecutive stable cycles required before a decision is accepted (0 = no debounce)
- CNT_W, 6, integrator width in bits (≥2)

Ports:
- clk  in  1  single clock; rising edge
- rst  in  1  reset, synchronous, active-high
- ena  in  1  global enable; low freezes all state and forces oe=0
- mode  in  2  00 CMP_TRI, 01 CMP_HOLD, 10 INTEG, 11 reserved (behaves as CMP_TRI)
- vip  in  N_CH  non-inverting inputs, asynchronous
- vin  in  N_CH  inverting inputs, asynchronous
- out  out  N_CH  output value per channel
- oe  out  N_CH  output enable per channel (1 = drive out, 0 = hi-Z)
- level  out  N_CH*CNT_W  integrator counts, channel i at [i*CNT_W +: CNT_W]

## Operation
- Input class per channel from synchronised pair: UP (vip=1,vin=0), DN (vip=0,vin=1), EQ (equal).
- Debounce: candidate class accepted once seen on DEB+1 consecutive synchronised samples; any change restarts the count. Accepted class register resets to EQ.
- Channel FSM states: IDLE, DRV_HI, DRV_LO.
  - IDLE: oe=0, out=0. Accepted UP → DRV_HI; DN → DRV_LO.
  - DRV_HI: oe=1, out=1. DN → DRV_LO. EQ → IDLE in CMP_TRI; stay in CMP_HOLD.
  - DRV_LO: oe=1, out=0. UP → DRV_HI. EQ as above.
- INTEG mode: FSM bypassed; each cycle accepted UP increments count, DN decrements, EQ holds; saturating at 2^CNT_W−1 and 0 (no wrap). out = count[CNT_W−1], oe=1.
- level reflects count in all modes; count only changes in INTEG.
- Mode change (mode differs from previous-cycle registered mode): on that edge all channels go to IDLE, count to midpoint 2^(CNT_W−1), debounce counters and accepted class cleared; synchronisers unaffected.
- ena=0: FSMs, counts, debounce hold; oe forced 0 combinationally from registered ena; out holds. Synchronisers keep running.
- Channels fully independent; no cross-channel interaction.

## Timing
- Reset (rst=1 at edge): out=0, oe=0, state IDLE, count=2^(CNT_W−1), accepted class EQ, debounce 0, registered mode=00, synchronisers 0. Reset mid-operation overrides everything on that edge, including mode change.
- Latency: input pair changed and held before edge k → out/oe (or count step) updates at edge k+2+DEB. Glitch shorter than DEB+1 synchronised cycles: no output change.
- Simultaneous accepted UP at count max / DN at 0: count holds, out unchanged.
- Mode change and accepted class on same edge: mode change wins; the class is discarded, debounce restarts.
- ena deasserted and reasserted: resumes from frozen state, no re-debounce of the held class.
- All outputs registered; no combinational path from vip/vin to out/oe.

## Structure
- Package digi_ota_pkg: mode encoding enum (CMP_TRI, CMP_HOLD, INTEG), class enum (EQ, UP, DN), FSM state enum (IDLE, DRV_HI, DRV_LO), midpoint constant function of CNT_W.
- Sub-module digi_ota_chan: one channel (synchroniser, debounce, FSM, integrator); top generates N_CH instances and shares registered mode/ena and mode-change strobe.

## Test plan
- Reset: assert rst 2 cycles with vip=vin=all 1s → out=0, oe=0, level each = 32 (CNT_W=6).
- CMP_TRI, DEB=2: ch0 vip=1,vin=0 held → oe[0]=1,out[0]=1 exactly 4 edges later; set vin=1 → oe[0]=0 4 edges later; 2-cycle glitch of vip on ch1 → no change.
- CMP_HOLD: UP then EQ → out stays 1, oe stays 1; then DN → out=0 after 4 edges.
- INTEG: ch2 UP held 40 cycles → level saturates at 63, out=1; then DN held 70 cycles → level 0, out=0, no wrap.
- Mode change mid-drive: in CMP_HOLD driving high, switch to INTEG → next edge oe=1, level=32, debounce restarts; switch back → state IDLE, oe=0.
- ena low for 10 cycles during INTEG UP → oe=0, level frozen; ena high → counting resumes from frozen value next accepted cycle.

Source files
------------

// File: rtl/digi_ota_pkg.sv
// Shared types and constants for the clocked multi-channel digital OTA array.
package digi_ota_pkg;

    typedef enum logic [1:0] {
        CMP_TRI  = 2'b00,
        CMP_HOLD = 2'b01,
        INTEG    = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        EQ = 2'b00,
        UP = 2'b01,
        DN = 2'b10
    } cls_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DRV_HI = 2'b01,
        DRV_LO = 2'b10
    } state_e;

    function automatic int unsigned midpoint(input int unsigned cnt_w);
        return 32'd1 << (cnt_w - 1);
    endfunction

endpackage

// File: rtl/digi_ota_chan.sv
// One comparator channel: 2-FF synchronisers, debounce, drive FSM and saturating integrator.
module digi_ota_chan
    import digi_ota_pkg::*;
#(
    parameter int unsigned DEB   = 2,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             mode_chg,
    input  logic             integ,
    input  logic             hold,
    input  logic             vip,
    input  logic             vin,
    output logic             out,
    output logic             oe_raw,
    output logic [CNT_W-1:0] level
);

    localparam int unsigned DW = (DEB > 1) ? $clog2(DEB) : 1;
    localparam logic [DW-1:0] CntMax = (DEB > 0) ? DW'(DEB - 1) : '0;
    localparam logic [CNT_W-1:0] Mid = CNT_W'(midpoint(CNT_W));

    logic             s1_p, s2_p, s1_n, s2_n;
    cls_e             cls, cand_q, acc_q, acc_d;
    logic [DW-1:0]    dcnt_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit;

    always_comb begin
        cls = EQ;
        if (s2_p && !s2_n) begin
            cls = UP;
        end else if (!s2_p && s2_n) begin
            cls = DN;
        end
        // The sample completing the stable run is accepted on the same edge.
        hit   = (DEB == 0) || ((cls == cand_q) && (dcnt_q == CntMax));
        acc_d = hit ? cls : acc_q;

        state_d = state_q;
        if (!integ) begin
            unique case (state_q)
                IDLE: begin
                    if (acc_d == UP) state_d = DRV_HI;
                    else if (acc_d == DN) state_d = DRV_LO;
                end
                DRV_HI: begin
                    if (acc_d == DN) state_d = DRV_LO;
                    else if (acc_d == EQ && !hold) state_d = IDLE;
                end
                DRV_LO: begin
                    if (acc_d == UP) state_d = DRV_HI;
                    else if (acc_d == EQ && !hold) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        cnt_d = cnt_q;
        if (integ) begin
            if (acc_d == UP && cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end else if (acc_d == DN && cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_p    <= 1'b0;
            s2_p    <= 1'b0;
            s1_n    <= 1'b0;
            s2_n    <= 1'b0;
            cand_q  <= EQ;
            acc_q   <= EQ;
            dcnt_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= Mid;
        end else begin
            s1_p <= vip;
            s2_p <= s1_p;
            s1_n <= vin;
            s2_n <= s1_n;
            if (mode_chg) begin
                cand_q  <= EQ;
                acc_q   <= EQ;
                dcnt_q  <= '0;
                state_q <= IDLE;
                cnt_q   <= Mid;
            end else if (run) begin
                if (cls != cand_q) begin
                    cand_q <= cls;
                    dcnt_q <= '0;
                end else if (dcnt_q != CntMax) begin
                    dcnt_q <= dcnt_q + 1'b1;
                end
                acc_q   <= acc_d;
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end
    end

    assign out    = integ ? cnt_q[CNT_W-1] : (state_q == DRV_HI);
    assign oe_raw = integ || (state_q != IDLE);
    assign level  = cnt_q;

endmodule

// File: rtl/digi_ota_array.sv
// N_CH independent clocked digital comparators with tri-state outputs and integrator mode.
module digi_ota_array
    import digi_ota_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned DEB   = 2,
    parameter int unsigned CNT_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [1:0]            mode,
    input  logic [N_CH-1:0]       vip,
    input  logic [N_CH-1:0]       vin,
    output logic [N_CH-1:0]       out,
    output logic [N_CH-1:0]       oe,
    output logic [N_CH*CNT_W-1:0] level
);

    logic [1:0]      mode_q;
    logic            ena_q;
    logic            mode_chg;
    logic            integ;
    logic            hold;
    logic [N_CH-1:0] oe_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= CMP_TRI;
            ena_q  <= 1'b0;
        end else begin
            ena_q <= ena;
            // Mode is frozen with the rest of the state while disabled.
            if (ena_q) begin
                mode_q <= mode;
            end
        end
    end

    assign mode_chg = ena_q && (mode != mode_q);
    assign integ    = (mode_q == INTEG);
    assign hold     = (mode_q == CMP_HOLD);

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        digi_ota_chan #(
            .DEB   (DEB),
            .CNT_W (CNT_W)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .run      (ena_q),
            .mode_chg (mode_chg),
            .integ    (integ),
            .hold     (hold),
            .vip      (vip[i]),
            .vin      (vin[i]),
            .out      (out[i]),
            .oe_raw   (oe_raw[i]),
            .level    (level[i*CNT_W +: CNT_W])
        );
    end

    assign oe = oe_raw & {N_CH{ena_q}};

endmodule
